// File: rtl/edge_event_pkg.sv
// edge_event_pkg: parameter defaults, legal minimums and counter sizing for edge_event_unit.
package edge_event_pkg;
    localparam int DEF_WIDTH           = 8;
    localparam int DEF_SYNC_STAGES     = 2;
    localparam int DEF_DEBOUNCE_CYCLES = 4;
    localparam int MIN_SYNC_STAGES     = 2;
    localparam int MIN_DEBOUNCE_CYCLES = 1;
    function automatic int cnt_width(input int cycles);
        return $clog2(cycles + 1);
    endfunction
endpackage

// File: rtl/edge_event_channel.sv
// edge_event_channel: one input channel -- synchroniser, debounce, edge pulses and sticky pending flag.
module edge_event_channel
    import edge_event_pkg::*;
#(
    parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_in,
    input  logic i_rise_en,
    input  logic i_fall_en,
    input  logic i_clr,
    output logic o_level,
    output logic o_rise,
    output logic o_fall,
    output logic o_pending,
    output logic o_accept
);
    localparam int CW = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
    logic [SYNC_STAGES-1:0] r_sync;
    logic [CW-1:0]          r_cnt;
    logic                   r_level, r_rise, r_fall, r_pending;
    logic                   w_s, w_diff, w_accept;
    assign w_s      = r_sync[SYNC_STAGES-1];
    assign w_diff   = w_s != r_level;
    assign w_accept = w_diff && (r_cnt == LAST);
    // Counter tops out at LAST, where acceptance clears it, so it never wraps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync    <= '0;
            r_cnt     <= '0;
            r_level   <= 1'b0;
            r_rise    <= 1'b0;
            r_fall    <= 1'b0;
            r_pending <= 1'b0;
        end else begin
            r_sync    <= {r_sync[SYNC_STAGES-2:0], i_in};
            r_cnt     <= (w_diff && !w_accept) ? r_cnt + 1'b1 : '0;
            r_level   <= w_accept ? w_s : r_level;
            r_rise    <= w_accept && w_s;
            r_fall    <= w_accept && !w_s;
            r_pending <= (r_rise & i_rise_en) | (r_fall & i_fall_en) | (r_pending & ~i_clr);
        end
    end
    assign o_level   = r_level;
    assign o_rise    = r_rise;
    assign o_fall    = r_fall;
    assign o_pending = r_pending;
    assign o_accept  = w_accept;
endmodule

// File: rtl/edge_event_unit.sv
// edge_event_unit: WIDTH debounced edge-event channels with a shared change strobe and interrupt.
module edge_event_unit
    import edge_event_pkg::*;
#(
    parameter int WIDTH           = DEF_WIDTH,
    parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in,
    input  logic [WIDTH-1:0] rise_en,
    input  logic [WIDTH-1:0] fall_en,
    input  logic [WIDTH-1:0] clr,
    output logic [WIDTH-1:0] level,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic             changed,
    output logic [WIDTH-1:0] pending,
    output logic             irq
);
    if (WIDTH < 1) begin : g_bad_width
        $error("edge_event_unit: WIDTH must be at least 1");
    end
    if (SYNC_STAGES < MIN_SYNC_STAGES) begin : g_bad_sync
        $error("edge_event_unit: SYNC_STAGES below minimum");
    end
    if (DEBOUNCE_CYCLES < MIN_DEBOUNCE_CYCLES) begin : g_bad_deb
        $error("edge_event_unit: DEBOUNCE_CYCLES below minimum");
    end
    logic [WIDTH-1:0] w_accept;
    logic             r_changed;
    for (genvar i = 0; i < WIDTH; i++) begin : g_ch
        edge_event_channel #(
            .SYNC_STAGES    (SYNC_STAGES),
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_ch (
            .clk      (clk),
            .rst_n    (rst_n),
            .i_in     (in[i]),
            .i_rise_en(rise_en[i]),
            .i_fall_en(fall_en[i]),
            .i_clr    (clr[i]),
            .o_level  (level[i]),
            .o_rise   (rise[i]),
            .o_fall   (fall[i]),
            .o_pending(pending[i]),
            .o_accept (w_accept[i])
        );
    end
    // Registered from the same accept terms that load rise/fall, so it lines up with them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_changed <= 1'b0;
        else        r_changed <= |w_accept;
    end
    assign changed = r_changed;
    assign irq     = |pending;
endmodule

// File: tb/tb_edge_event_unit.sv
// tb_edge_event_unit: directed checks of edge_event_unit with WIDTH=4, SYNC_STAGES=2, DEBOUNCE_CYCLES=3.
module tb_edge_event_unit;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] d_in, rise_en, fall_en, clr;
    logic [3:0] level, rise, fall, pending;
    logic       changed, irq;
    int         compared = 0;
    int         mismatched = 0;
    int         nr, nf, both;

    edge_event_unit #(.WIDTH(4), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(3)) dut (
        .clk(clk), .rst_n(rst_n), .in(d_in), .rise_en(rise_en), .fall_en(fall_en), .clr(clr),
        .level(level), .rise(rise), .fall(fall), .changed(changed), .pending(pending), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n = 1'b1; d_in = 4'hF; rise_en = 4'h0; fall_en = 4'h0; clr = 4'h0;
        // reset asserted between edges: outputs clear without a clock
        @(negedge clk); #2 rst_n = 1'b0; #1;
        chk("rst_level", level, 0);
        chk("rst_rise", rise, 0);
        chk("rst_fall", fall, 0);
        chk("rst_changed", changed, 0);
        chk("rst_pending", pending, 0);
        chk("rst_irq", irq, 0);
        d_in = 4'h0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("post_rst_pulse", {rise, fall, changed, level}, 0);
        end
        // latency: pulse at edge E+4, pending at E+5
        rise_en = 4'h1; d_in = 4'h1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("lat_early", {rise, changed, level}, 0);
        end
        @(negedge clk);
        chk("lat_rise", rise, 4'h1);
        chk("lat_changed", changed, 1);
        chk("lat_level", level, 4'h1);
        chk("lat_pend_early", pending, 0);
        @(negedge clk);
        chk("lat_rise_end", rise, 0);
        chk("lat_changed_end", changed, 0);
        chk("lat_pending", pending, 4'h1);
        chk("lat_irq", irq, 1);
        clr = 4'h1;
        @(negedge clk);
        clr = 4'h0;
        chk("lat_clr", pending, 0);
        chk("lat_clr_irq", irq, 0);
        // glitch: in[1] high for two cycles only
        rise_en = 4'hF; fall_en = 4'hF; d_in = 4'h3;
        repeat (2) @(negedge clk);
        d_in = 4'h1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("glitch_ch1", {rise[1], fall[1], level[1]}, 0);
        end
        chk("glitch_pending", pending, 0);
        // enable gating on channel 2
        rise_en = 4'h0; fall_en = 4'h4; d_in = 4'h5;
        nr = 0; nf = 0; both = 0;
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            nr += int'(rise[2]);
            both += int'(rise[2] & fall[2]);
        end
        chk("gate_rise_count", nr, 1);
        chk("gate_level_hi", level, 4'h5);
        chk("gate_pend_after_rise", pending, 0);
        d_in = 4'h1;
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            nf += int'(fall[2]);
            both += int'(rise[2] & fall[2]);
        end
        chk("gate_fall_count", nf, 1);
        chk("gate_both", both, 0);
        chk("gate_pend_after_fall", pending, 4'h4);
        clr = 4'h4;
        @(negedge clk);
        clr = 4'h0;
        chk("gate_clr", pending, 0);
        // set/clear collision on channel 3
        rise_en = 4'h8; fall_en = 4'h0; d_in = 4'h9;
        repeat (4) @(negedge clk);
        @(negedge clk);
        chk("coll_rise", rise, 4'h8);
        clr = 4'h8;
        @(negedge clk);
        clr = 4'h0;
        chk("coll_set_wins", pending, 4'h8);
        @(negedge clk);
        chk("coll_hold", pending, 4'h8);
        clr = 4'h8;
        @(negedge clk);
        clr = 4'h0;
        chk("coll_clear", pending, 0);
        // reset in the middle of channel 0 debounce
        rise_en = 4'h1; d_in = 4'h8;
        repeat (8) @(negedge clk);
        chk("mid_pre_level", level, 4'h8);
        d_in = 4'h9;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("mid_no_early", rise[0], 0);
        end
        #2 rst_n = 1'b0; #1;
        chk("mid_rst_level", level, 0);
        chk("mid_rst_rise", rise, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("mid_wait", rise, 0);
        end
        @(negedge clk);
        chk("mid_rise", rise, 4'h9);
        chk("mid_changed", changed, 1);
        @(negedge clk);
        chk("mid_once", rise, 0);
        chk("mid_pending", pending, 4'h1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
